muldiv_sequencer: RTL and testbench

Iterative multiply/divide unit with its sequencing FSM and HI/LO result registers. It serves MULT/MULTU/DIV/DIVU issued from EX. It computes one bit per cycle and raises a stall request into the pipeline hazard logic. Any instruction that reads HI/LO, or issues a new mult/div, is held in ID until the result is committed.

---
 rtl/muldiv_sequencer_if.sv | 35 +++
 rtl/muldiv_sequencer.sv | 154 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Bundle between EX/ID and the iterative multiply/divide unit.
//
// Handshake: start is a level request that the unit samples only while it is
// IDLE; it is accepted on the rising edge where state is IDLE, start = 1 and
// flush = 0, and op/src_a/src_b are captured on that same edge. There is no
// ready signal: while the unit is busy a later start is ignored, and
// the pipeline keeps dependent instructions out of EX through stall_req.
// done is a one-cycle pulse that follows the edge committing hi/lo.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             id_hilo_use;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall_req;
    logic             done;
    logic             div_by_zero;
    logic [1:0]       dbg_state;

    modport master (
        output start, op, src_a, src_b, flush, id_hilo_use,
        input  hi, lo, busy, stall_req, done, div_by_zero, dbg_state
    );

    modport slave (
        input  start, op, src_a, src_b, flush, id_hilo_use,
        output hi, lo, busy, stall_req, done, div_by_zero, dbg_state
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one bit per cycle over unsigned
// magnitudes, sign fix-up at the end, then commit into the HI/LO registers.
// Multiply and divide share one 2*WIDTH accumulator: for multiply it holds
// {partial product, multiplier}, for divide {remainder, dividend/quotient}.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    muldiv_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic                 div_q;      // 1: divide, 0: multiply
    logic                 neg_q_q;    // negate product / quotient
    logic                 neg_r_q;    // negate remainder
    logic                 dz_q;       // divide with zero divisor
    logic [WIDTH-1:0]     src_a_q;    // raw dividend, returned on divide by zero
    logic [WIDTH-1:0]     opnd_q;     // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     hi_q, lo_q;

    // Operand magnitudes. An unsigned WIDTH-bit magnitude holds 2^(WIDTH-1)
    // exactly, so the most-negative operand needs no special handling.
    logic             is_signed, is_div, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    // Operand decode and magnitude conversion for the instruction in EX
    always_comb begin
        is_signed = ~bus.op[0];
        is_div    = bus.op[1];
        a_neg     = is_signed & bus.src_a[WIDTH-1];
        b_neg     = is_signed & bus.src_b[WIDTH-1];
        a_mag     = a_neg ? (~bus.src_a + 1'b1) : bus.src_a;
        b_mag     = b_neg ? (~bus.src_b + 1'b1) : bus.src_b;
    end

    // One iteration step for each operation
    logic [WIDTH:0]       mul_sum, div_trial, div_diff;
    logic                 div_ok;
    logic [2*WIDTH-1:0]   mul_next, div_next;

    // Shift-add multiply step and restoring divide step
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_trial - {1'b0, opnd_q};
        div_ok    = ~div_diff[WIDTH];
        div_next  = {(div_ok ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ok};
    end

    // Sign correction and special cases, consumed on the FIXUP exit edge
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, res_hi, res_lo;

    // Final result selection
    always_comb begin
        prod_fix = neg_q_q ? (~acc_q + 1'b1) : acc_q;
        quo_fix  = neg_q_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        rem_fix  = neg_r_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
        if (div_q) begin
            if (dz_q) begin
                res_hi = src_a_q;
                res_lo = '1;
            end else begin
                res_hi = rem_fix;
                res_lo = quo_fix;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; flush returns any active state to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start && !bus.flush) state_d = S_CALC;
            S_CALC: begin
                if (bus.flush)                             state_d = S_IDLE;
                else if (cnt_q == CNT_W'(WIDTH - 1))       state_d = S_FIXUP;
            end
            S_FIXUP: state_d = bus.flush ? S_IDLE : S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand capture, iteration and HI/LO commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            div_q   <= 1'b0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            dz_q    <= 1'b0;
            src_a_q <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.flush) begin
                        cnt_q   <= '0;
                        div_q   <= is_div;
                        neg_q_q <= a_neg ^ b_neg;
                        neg_r_q <= a_neg;
                        dz_q    <= is_div && (bus.src_b == '0);
                        src_a_q <= bus.src_a;
                        opnd_q  <= is_div ? b_mag : a_mag;
                        acc_q   <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
                    end
                end
                S_CALC: begin
                    cnt_q <= cnt_q + 1'b1;
                    acc_q <= div_q ? div_next : mul_next;
                end
                S_FIXUP: begin
                    if (!bus.flush) begin
                        hi_q <= res_hi;
                        lo_q <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.stall_req   = bus.id_hilo_use && (state_q == S_CALC || state_q == S_FIXUP);
    assign bus.done        = (state_q == S_DONE);
    assign bus.div_by_zero = (state_q == S_DONE) && dz_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed cases, abort cases and random operations
// checked against a plain-arithmetic reference model.
module tb_muldiv_sequencer;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [W-1:0] exp_q[$];

    // Clock
    always #5 clk = ~clk;

    muldiv_sequencer_if #(.WIDTH(W)) bus();

    muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Reference: signed results from 64-bit integer arithmetic (SV division
    // truncates toward zero and % follows the dividend's sign).
    function automatic void ref_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                      output logic [W-1:0] r_hi, output logic [W-1:0] r_lo, output logic dz);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        p  = '0;
        r_hi = '0;
        r_lo = '0;
        if (op[1] && b == '0) begin
            r_hi = a;
            r_lo = '1;
            dz   = 1'b1;
        end else begin
            case (op)
                2'b00: p = sa * sb;
                2'b01: p = {32'b0, a} * {32'b0, b};
                2'b10: begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
                default: begin
                    p = {a % b, a / b};
                end
            endcase
            r_hi = p[63:32];
            r_lo = p[31:0];
        end
    endfunction

    // Issue one operation and follow it cycle by cycle.
    // poke_at: cycle for a stray start during CALC; abort_at: cycle to flush/reset.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic use_hilo, input int poke_at,
                          input int abort_at, input bit abort_rst);
        logic [W-1:0] prev_hi, prev_lo, e_hi, e_lo;
        logic         e_dz, dz_at_done, dz_stray, stall_bad, early_change, alive;
        int           busy_n, done_n, done_at;
        prev_hi = bus.hi;
        prev_lo = bus.lo;
        ref_model(op, a, b, e_hi, e_lo, e_dz);
        exp_q.push_back(e_hi);
        exp_q.push_back(e_lo);
        busy_n = 0; done_n = 0; done_at = -1;
        dz_at_done = 1'b0; dz_stray = 1'b0; stall_bad = 1'b0; early_change = 1'b0;

        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
        bus.id_hilo_use = use_hilo;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.src_a = $urandom; bus.src_b = $urandom;

        for (int j = 0; j <= W + 2; j++) begin
            alive = (abort_at < 0) || (j <= abort_at);
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_n++;
                done_at = j;
                dz_at_done = bus.div_by_zero;
            end else if (bus.div_by_zero) begin
                dz_stray = 1'b1;
            end
            if (bus.stall_req !== (use_hilo && alive && j <= W)) stall_bad = 1'b1;
            if (j <= W && (bus.hi !== prev_hi || bus.lo !== prev_lo)) early_change = 1'b1;
            if (j == abort_at) begin
                if (abort_rst) begin
                    rst_n = 1'b0;
                    #1;
                    check_eq({tag, "/rst_hilo"}, {bus.hi, bus.lo}, 64'h0);
                    check_eq({tag, "/rst_flags"},
                             {bus.busy, bus.stall_req, bus.done, bus.div_by_zero}, 4'b0000);
                    void'(exp_q.pop_front());
                    void'(exp_q.pop_front());
                    @(negedge clk);
                    rst_n = 1'b1;
                    bus.id_hilo_use = 1'b0;
                    return;
                end
                bus.flush = 1'b1;
            end
            if (j == poke_at) begin
                bus.start = 1'b1; bus.op = 2'($urandom); bus.src_a = $urandom; bus.src_b = $urandom;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            bus.flush = 1'b0;
        end
        bus.id_hilo_use = 1'b0;

        e_hi = exp_q.pop_front();
        e_lo = exp_q.pop_front();
        check_eq({tag, "/stall"}, stall_bad, 1'b0);
        if (abort_at >= 0) begin
            check_eq({tag, "/flush_hilo"}, {bus.hi, bus.lo}, {prev_hi, prev_lo});
            check_eq({tag, "/flush_done"}, done_n, 0);
            check_eq({tag, "/flush_busy"}, busy_n, abort_at + 1);
        end else begin
            check_eq({tag, "/hi"}, bus.hi, e_hi);
            check_eq({tag, "/lo"}, bus.lo, e_lo);
            check_eq({tag, "/done_once"}, done_n, 1);
            check_eq({tag, "/done_at"}, done_at, W + 1);
            check_eq({tag, "/busy_cycles"}, busy_n, W + 2);
            check_eq({tag, "/dz"}, {dz_at_done, dz_stray}, {e_dz, 1'b0});
            check_eq({tag, "/hold_until_commit"}, early_change, 1'b0);
        end
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'h1;
            2:       return '1;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.start = 1'b0; bus.op = 2'b00; bus.src_a = '0; bus.src_b = '0;
        bus.flush = 1'b0; bus.id_hilo_use = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("reset/hilo", {bus.hi, bus.lo}, 64'h0);
        check_eq("reset/flags", {bus.busy, bus.stall_req, bus.done, bus.div_by_zero}, 4'b0000);
        check_eq("reset/state", bus.dbg_state, 2'd0);
        rst_n = 1'b1;
        bus.id_hilo_use = 1'b0;

        // Directed cases with values fixed independently of the model
        run_op("multu_ff", 2'b01, 32'hFFFF_FFFF, 32'h2, 1'b0, -1, -1, 1'b0);
        check_eq("tp/multu_ff", {bus.hi, bus.lo}, 64'h0000_0001_FFFF_FFFE);
        run_op("mult_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, -1, -1, 1'b0);
        check_eq("tp/mult_m3x5", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("mult_minmin", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, -1, -1, 1'b0);
        check_eq("tp/mult_minmin", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);
        run_op("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, -1, -1, 1'b0);
        check_eq("tp/div_m7d2", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, -1, 1'b0);
        check_eq("tp/div_ovf", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
        run_op("divu_by0", 2'b11, 32'd100, 32'd0, 1'b0, -1, -1, 1'b0);
        check_eq("tp/divu_by0", {bus.hi, bus.lo}, 64'h0000_0064_FFFF_FFFF);
        run_op("div_by0", 2'b10, 32'hFFFF_FF00, 32'd0, 1'b0, -1, -1, 1'b0);
        run_op("divu_stall", 2'b11, 32'd100, 32'd7, 1'b1, 5, -1, 1'b0);
        check_eq("tp/divu_stall", {bus.hi, bus.lo}, 64'h0000_0002_0000_000E);

        // Preload, then flush on the 10th CALC cycle, then reset mid-CALC
        run_op("preload", 2'b01, 32'h6666_6666, 32'h2AAA_AAAB, 1'b0, -1, -1, 1'b0);
        check_eq("tp/preload", {bus.hi, bus.lo}, 64'h1111_1111_2222_2222);
        run_op("flush10", 2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, -1, 9, 1'b0);
        run_op("rst_mid", 2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, -1, 5, 1'b1);
        check_eq("rst_mid/after", {bus.hi, bus.lo, 3'(bus.dbg_state)}, 67'h0);

        // start together with flush in IDLE is not accepted
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b01; bus.src_a = 32'd3; bus.src_b = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        check_eq("start_flush/busy", bus.busy, 1'b0);
        repeat (3) @(posedge clk);
        #1 check_eq("start_flush/hilo", {bus.hi, bus.lo}, 64'h0);

        // Random operations
        for (int n = 0; n < 24; n++) begin
            run_op($sformatf("rnd%0d", n), 2'($urandom_range(0, 3)), pick_operand(), pick_operand(),
                   1'($urandom_range(0, 1)), -1, -1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
